piso_serializer: RTL and testbench

- Upstream feeder for the serial two's-complement stage.
- Accepts a WIDTH-bit parallel word over a valid/ready handshake and emits it one bit per t_clk cycle, LSB first, on ser_o.
- Drives first_o high on each word's LSB so the downstream stage can restart its carry/complement state per word.
- Optional idle gap between words; hold input stalls the stream.

---
 rtl/piso_serializer_pkg.sv | 22 ++
 rtl/piso_serializer_if.sv | 32 +++
 rtl/piso_serializer.sv | 124 ++++++++++++
 tb/tb_piso_serializer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg: types and helpers shared by the serial-stream blocks.
//   ser_state_t : serializer FSM states (idle / shifting / inter-word gap)
//   cnt_w()     : bit-counter width for a given word width, never below 1
//   GAP_W       : width of the inter-word gap counter
// No ports (package).
// -----------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } ser_state_t;

    localparam int GAP_W = 4;

    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// -----------------------------------------------------------------------------
// piso_serializer_if: parallel-in / serial-out stream bundle.
//   in_data/in_valid/in_ready : parallel word handshake (upstream -> serializer)
//   hold_i                    : stall, shared with the downstream serial stage
//   ser_o/bit_valid_o         : serial bit and its qualifier
//   first_o/last_o            : LSB / MSB markers for the current bit
//   busy_o                    : serializer is not idle
// master = word producer / serial consumer side; slave = serializer.
// -----------------------------------------------------------------------------
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             hold_i;
    logic             ser_o;
    logic             bit_valid_o;
    logic             first_o;
    logic             last_o;
    logic             busy_o;

    modport master (
        output in_data, in_valid, hold_i,
        input  in_ready, ser_o, bit_valid_o, first_o, last_o, busy_o
    );

    modport slave (
        input  in_data, in_valid, hold_i,
        output in_ready, ser_o, bit_valid_o, first_o, last_o, busy_o
    );
endinterface

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer: takes a WIDTH-bit word over valid/ready and shifts it out
// LSB first, one bit per t_clk cycle, optionally followed by GAP idle cycles.
// Ports:
//   t_clk : clock, rising edge
//   r     : asynchronous active-high reset; drops any word in flight
//   bus   : piso_serializer_if.slave (handshake, hold, serial outputs)
// All serial outputs are registered; in_ready and busy_o are decoded from
// the current state.
// -----------------------------------------------------------------------------
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic           t_clk,
    input  logic           r,
    piso_serializer_if.slave bus
);

    localparam int                CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);
    // Gap counter counts GAP-1 down to 0, giving exactly GAP idle cycles.
    localparam logic [GAP_W-1:0]  GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    ser_state_t       r_state, w_state;
    logic [WIDTH-1:0] r_sreg,  w_sreg;
    logic [CW-1:0]    r_cnt,   w_cnt;
    logic [GAP_W-1:0] r_gcnt,  w_gcnt;
    logic             r_ser,   w_ser;
    logic             r_bv,    w_bv;
    logic             r_first, w_first;
    logic             r_last,  w_last;
    logic             w_ready;
    logic             w_accept;

    // With no gap, the MSB cycle can take the next word so streams run
    // back-to-back. Hold blocks acceptance because every register is frozen.
    assign w_ready  = !bus.hold_i &&
                      ((r_state == ST_IDLE) ||
                       ((r_state == ST_SHIFT) && (r_cnt == CNT_LAST) && (GAP == 0)));
    assign w_accept = bus.in_valid && w_ready;

    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            r_state <= ST_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_gcnt  <= '0;
            r_ser   <= 1'b0;
            r_bv    <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_sreg  <= w_sreg;
            r_cnt   <= w_cnt;
            r_gcnt  <= w_gcnt;
            r_ser   <= w_ser;
            r_bv    <= w_bv;
            r_first <= w_first;
            r_last  <= w_last;
        end
    end

    always_comb begin
        w_state = r_state;
        w_sreg  = r_sreg;
        w_cnt   = r_cnt;
        w_gcnt  = r_gcnt;
        w_ser   = r_ser;
        w_bv    = r_bv;
        w_first = r_first;
        w_last  = r_last;

        if (w_accept) begin
            // LSB goes straight to the output register; the rest waits in sreg.
            w_sreg  = bus.in_data >> 1;
            w_ser   = bus.in_data[0];
            w_first = 1'b1;
            w_bv    = 1'b1;
            w_last  = 1'b0;
            w_cnt   = '0;
            w_state = ST_SHIFT;
        end else if (!bus.hold_i) begin
            case (r_state)
                ST_SHIFT: begin
                    if (r_cnt != CNT_LAST) begin
                        w_ser   = r_sreg[0];
                        w_sreg  = r_sreg >> 1;
                        w_cnt   = r_cnt + 1'b1;
                        w_first = 1'b0;
                        w_last  = ((r_cnt + 1'b1) == CNT_LAST);
                    end else begin
                        if (GAP > 0) begin
                            w_state = ST_GAP;
                            w_gcnt  = GAP_LOAD;
                        end else begin
                            w_state = ST_IDLE;
                        end
                        w_ser   = 1'b0;
                        w_bv    = 1'b0;
                        w_first = 1'b0;
                        w_last  = 1'b0;
                    end
                end
                ST_GAP: begin
                    if (r_gcnt == '0) w_state = ST_IDLE;
                    else              w_gcnt  = r_gcnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = w_ready;
    assign bus.ser_o       = r_ser;
    assign bus.bit_valid_o = r_bv;
    assign bus.first_o     = r_first;
    assign bus.last_o      = r_last;
    assign bus.busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: u0 runs with GAP=0, u2 with GAP=2.
// Words accepted on the handshake are expanded into expected bits on a
// per-instance queue; a negedge monitor pops and checks each live bit.
module tb_piso_serializer;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } exp_t;

    logic t_clk = 1'b0;
    logic r;
    always #5 t_clk = ~t_clk;

    piso_serializer_if #(.WIDTH(8)) if0 ();
    piso_serializer_if #(.WIDTH(8)) if2 ();

    piso_serializer #(.WIDTH(8), .GAP(0)) u0 (.t_clk(t_clk), .r(r), .bus(if0));
    piso_serializer #(.WIDTH(8), .GAP(2)) u2 (.t_clk(t_clk), .r(r), .bus(if2));

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q0[$];
    exp_t q2[$];
    exp_t last0, last2;
    logic hp0, hp2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input int id, input logic [7:0] d);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.b = d[i];
            e.f = (i == 0);
            e.l = (i == 7);
            if (id == 0) q0.push_back(e);
            else         q2.push_back(e);
        end
    endtask

    // One serial-output check per cycle; a held cycle must repeat the last bit.
    task automatic mon(input int id, input logic bv, input logic ser,
                       input logic first, input logic last, input logic held);
        exp_t e;
        int   sz;
        if (bv) begin
            if (held) begin
                e = (id == 0) ? last0 : last2;
                chk($sformatf("u%0d_hold_repeat", id), {31'd0, ser}, {31'd0, e.b});
            end else begin
                sz = (id == 0) ? q0.size() : q2.size();
                chk($sformatf("u%0d_bit_expected", id), {31'd0, sz != 0}, 32'd1);
                if (sz != 0) begin
                    e = (id == 0) ? q0.pop_front() : q2.pop_front();
                    chk($sformatf("u%0d_ser", id),   {31'd0, ser},   {31'd0, e.b});
                    chk($sformatf("u%0d_first", id), {31'd0, first}, {31'd0, e.f});
                    chk($sformatf("u%0d_last", id),  {31'd0, last},  {31'd0, e.l});
                    if (id == 0) last0 = e;
                    else         last2 = e;
                end
            end
        end
    endtask

    always @(posedge t_clk) begin
        hp0 <= if0.hold_i;
        hp2 <= if2.hold_i;
    end

    always @(negedge t_clk) begin
        mon(0, if0.bit_valid_o, if0.ser_o, if0.first_o, if0.last_o, hp0);
        mon(2, if2.bit_valid_o, if2.ser_o, if2.first_o, if2.last_o, hp2);
        if (!r && if0.in_valid && if0.in_ready) push_word(0, if0.in_data);
        if (!r && if2.in_valid && if2.in_ready) push_word(2, if2.in_data);
    end

    task automatic step();
        @(posedge t_clk);
        #2;
    endtask

    initial begin
        r            = 1'b1;
        if0.in_data  = '0; if0.in_valid = 1'b0; if0.hold_i = 1'b0;
        if2.in_data  = '0; if2.in_valid = 1'b0; if2.hold_i = 1'b0;
        #1;
        // reset state
        chk("rst_ser",   {31'd0, if0.ser_o},       32'd0);
        chk("rst_bv",    {31'd0, if0.bit_valid_o}, 32'd0);
        chk("rst_first", {31'd0, if0.first_o},     32'd0);
        chk("rst_last",  {31'd0, if0.last_o},      32'd0);
        chk("rst_busy",  {31'd0, if0.busy_o},      32'd0);
        chk("rst_ready", {31'd0, if0.in_ready},    32'd1);
        step();
        r = 1'b0;

        // 1: single word 8'h35
        step();
        if0.in_data = 8'h35; if0.in_valid = 1'b1;
        step();
        for (int c = 1; c <= 8; c++) begin
            chk("w35_bv",    {31'd0, if0.bit_valid_o}, 32'd1);
            chk("w35_ready", {31'd0, if0.in_ready},    {31'd0, c == 8});
            chk("w35_first", {31'd0, if0.first_o},     {31'd0, c == 1});
            chk("w35_last",  {31'd0, if0.last_o},      {31'd0, c == 8});
            if (c == 1) if0.in_valid = 1'b0;
            step();
        end
        chk("w35_done_bv",   {31'd0, if0.bit_valid_o}, 32'd0);
        chk("w35_done_busy", {31'd0, if0.busy_o},      32'd0);

        // 2: back-to-back 8'h01, 8'h80
        step();
        if0.in_data = 8'h01; if0.in_valid = 1'b1;
        step();
        for (int c = 1; c <= 16; c++) begin
            chk("b2b_bv",    {31'd0, if0.bit_valid_o}, 32'd1);
            chk("b2b_first", {31'd0, if0.first_o},     {31'd0, c == 1 || c == 9});
            chk("b2b_last",  {31'd0, if0.last_o},      {31'd0, c == 8 || c == 16});
            if (c == 1) if0.in_data  = 8'h80;
            if (c == 9) if0.in_valid = 1'b0;
            step();
        end
        chk("b2b_done_bv", {31'd0, if0.bit_valid_o}, 32'd0);

        // 3: GAP=2 instance, 8'hFF then 8'h00
        step();
        if2.in_data = 8'hFF; if2.in_valid = 1'b1;
        step();
        for (int c = 1; c <= 20; c++) begin
            chk("gap_bv",    {31'd0, if2.bit_valid_o}, {31'd0, (c <= 8) || (c >= 12 && c <= 19)});
            chk("gap_ready", {31'd0, if2.in_ready},    {31'd0, c == 11});
            chk("gap_busy",  {31'd0, if2.busy_o},      {31'd0, c != 11});
            chk("gap_first", {31'd0, if2.first_o},     {31'd0, c == 1 || c == 12});
            if (c == 1)  if2.in_data  = 8'h00;
            if (c == 12) if2.in_valid = 1'b0;
            step();
        end
        step();
        chk("gap_done_busy", {31'd0, if2.busy_o}, 32'd0);

        // 4: hold for 3 cycles on bit 4 of 8'hA5
        step();
        if0.in_data = 8'hA5; if0.in_valid = 1'b1;
        step();
        for (int c = 1; c <= 11; c++) begin
            chk("hold_bv",   {31'd0, if0.bit_valid_o}, 32'd1);
            chk("hold_last", {31'd0, if0.last_o},      {31'd0, c == 11});
            if (c >= 5 && c <= 7) begin
                chk("hold_ready", {31'd0, if0.in_ready}, 32'd0);
                chk("hold_ser",   {31'd0, if0.ser_o},    32'd0);
            end
            if (c == 1) if0.in_valid = 1'b0;
            if (c == 4) if0.hold_i   = 1'b1;
            if (c == 7) if0.hold_i   = 1'b0;
            step();
        end
        chk("hold_done_bv", {31'd0, if0.bit_valid_o}, 32'd0);

        // 5: async reset at bit 5 of 8'h3C, then 8'h01
        step();
        if0.in_data = 8'h3C; if0.in_valid = 1'b1;
        step();
        for (int c = 1; c <= 4; c++) begin
            if (c == 1) if0.in_valid = 1'b0;
            step();
        end
        chk("arst_pre_bv", {31'd0, if0.bit_valid_o}, 32'd1);
        #1;
        r = 1'b1;
        q0.delete();
        #1;
        chk("arst_ser",   {31'd0, if0.ser_o},       32'd0);
        chk("arst_bv",    {31'd0, if0.bit_valid_o}, 32'd0);
        chk("arst_first", {31'd0, if0.first_o},     32'd0);
        chk("arst_last",  {31'd0, if0.last_o},      32'd0);
        chk("arst_busy",  {31'd0, if0.busy_o},      32'd0);
        chk("arst_ready", {31'd0, if0.in_ready},    32'd1);
        r = 1'b0;
        step();
        if0.in_data = 8'h01; if0.in_valid = 1'b1;
        step();
        for (int c = 1; c <= 8; c++) begin
            chk("post_first", {31'd0, if0.first_o}, {31'd0, c == 1});
            chk("post_bv",    {31'd0, if0.bit_valid_o}, 32'd1);
            if (c == 1) if0.in_valid = 1'b0;
            step();
        end
        chk("post_done_bv", {31'd0, if0.bit_valid_o}, 32'd0);

        // 6: in_valid pulsed while busy is ignored
        step();
        if0.in_data = 8'h5A; if0.in_valid = 1'b1;
        step();
        for (int c = 1; c <= 8; c++) begin
            chk("ign_bv",    {31'd0, if0.bit_valid_o}, 32'd1);
            chk("ign_ready", {31'd0, if0.in_ready},    {31'd0, c == 8});
            if (c == 1) if0.in_valid = 1'b0;
            if (c == 2) begin if0.in_data = 8'hAA; if0.in_valid = 1'b1; end
            if (c == 7) if0.in_valid = 1'b0;
            step();
        end
        chk("ign_done_bv",   {31'd0, if0.bit_valid_o}, 32'd0);
        chk("ign_done_busy", {31'd0, if0.busy_o},      32'd0);

        for (int i = 0; i < 4; i++) step();
        chk("q0_drained", q0.size(), 32'd0);
        chk("q2_drained", q2.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
